// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one multi-cycle, single-ported main memory between an
//   instruction-fetch port (I, read-only) and a data port (D, read/write).
//   Requests are serialised: D has priority, but when both ports are pending
//   the port that was not served last wins, so the grants alternate.
//   Each requester is stalled via its BUSYWAIT until its transaction is done.
//
// Ports
//   CLK, RESET                 clock (rising edge), async active-low reset
//   I_READ, I_ADDRESS          instruction block read request
//   I_READDATA, I_BUSYWAIT     returned instruction block, stall to I
//   D_READ, D_WRITE            data block read / write request (both = write)
//   D_ADDRESS, D_WRITEDATA     data block address and write data
//   D_READDATA, D_BUSYWAIT     returned data block, stall to D
//   MEM_READ, MEM_WRITE        memory strobes (registered)
//   MEM_ADDRESS, MEM_WRITEDATA memory address / write data (registered)
//   MEM_READDATA, MEM_BUSYWAIT memory read data and busy
//   ERROR                      sticky flag: a service timed out

module mem_arbiter #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output logic              ERROR
);

    localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_D,
        SERVE_I,
        DONE_D,
        DONE_I
    } state_e;

    state_e              state_q,  state_d;
    logic                last_d_q, last_d_d;   // 1: D was granted last
    logic                seen_q,   seen_d;     // memory has reported busy
    logic [CNT_W-1:0]    cnt_q,    cnt_d;      // cycles spent in SERVE
    logic                rd_q,     rd_d;
    logic                wr_q,     wr_d;
    logic [ADDR_W-1:0]   addr_q,   addr_d;
    logic [DATA_W-1:0]   wdata_q,  wdata_d;
    logic [DATA_W-1:0]   irdata_q, irdata_d;
    logic [DATA_W-1:0]   drdata_q, drdata_d;
    logic                err_q,    err_d;

    logic                d_req;
    logic                finish;

    assign d_req = D_READ | D_WRITE;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        seen_d   = seen_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        irdata_d = irdata_q;
        drdata_d = drdata_q;
        err_d    = err_q;
        finish   = 1'b0;

        case (state_q)
            IDLE: begin
                // D wins unless I is also waiting and D had the last grant.
                if (d_req && (!I_READ || !last_d_q)) begin
                    state_d = SERVE_D;
                    addr_d  = D_ADDRESS;
                    wdata_d = D_WRITEDATA;
                    wr_d    = D_WRITE;
                    rd_d    = ~D_WRITE;
                end else if (I_READ) begin
                    state_d = SERVE_I;
                    addr_d  = I_ADDRESS;
                    wr_d    = 1'b0;
                    rd_d    = 1'b1;
                end
            end

            SERVE_D, SERVE_I: begin
                cnt_d = cnt_q + 1'b1;
                // Completion uses the busy flag from earlier edges, so the
                // memory must have been seen busy at least once before.
                if (seen_q && !MEM_BUSYWAIT) begin
                    finish = 1'b1;
                    if (rd_q) begin
                        if (state_q == SERVE_D) begin
                            drdata_d = MEM_READDATA;
                        end else begin
                            irdata_d = MEM_READDATA;
                        end
                    end
                end else if (cnt_d == CNT_LIMIT) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else if (MEM_BUSYWAIT) begin
                    seen_d = 1'b1;
                end

                if (finish) begin
                    state_d  = (state_q == SERVE_D) ? DONE_D : DONE_I;
                    last_d_d = (state_q == SERVE_D);
                    rd_d     = 1'b0;
                    wr_d     = 1'b0;
                    seen_d   = 1'b0;
                    cnt_d    = '0;
                end
            end

            DONE_D, DONE_I: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            seen_q   <= 1'b0;
            cnt_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            irdata_q <= '0;
            drdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            seen_q   <= seen_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            irdata_q <= irdata_d;
            drdata_q <= drdata_d;
            err_q    <= err_d;
        end
    end

    // Stalls depend only on the request and the registered state, never on
    // MEM_BUSYWAIT, so a new request stalls in its very first cycle.
    assign I_BUSYWAIT    = I_READ & (state_q != DONE_I);
    assign D_BUSYWAIT    = d_req  & (state_q != DONE_D);

    assign MEM_READ      = rd_q;
    assign MEM_WRITE     = wr_q;
    assign MEM_ADDRESS   = addr_q;
    assign MEM_WRITEDATA = wdata_q;
    assign I_READDATA    = irdata_q;
    assign D_READDATA    = drdata_q;
    assign ERROR         = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Drives mem_arbiter with directed scenarios and random traffic against a
//   behavioural memory. A transaction-level model (owner, job, shadow memory)
//   predicts every output each cycle; directed scenarios add literal checks.

module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        I_READ = 1'b0;
    logic [5:0]  I_ADDRESS = '0;
    logic [31:0] I_READDATA;
    logic        I_BUSYWAIT;
    logic        D_READ = 1'b0;
    logic        D_WRITE = 1'b0;
    logic [5:0]  D_ADDRESS = '0;
    logic [31:0] D_WRITEDATA = '0;
    logic [31:0] D_READDATA;
    logic        D_BUSYWAIT;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA = '0;
    logic        MEM_BUSYWAIT = 1'b0;
    logic        ERROR;

    mem_arbiter #(
        .ADDR_W (6),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .I_READ       (I_READ),
        .I_ADDRESS    (I_ADDRESS),
        .I_READDATA   (I_READDATA),
        .I_BUSYWAIT   (I_BUSYWAIT),
        .D_READ       (D_READ),
        .D_WRITE      (D_WRITE),
        .D_ADDRESS    (D_ADDRESS),
        .D_WRITEDATA  (D_WRITEDATA),
        .D_READDATA   (D_READDATA),
        .D_BUSYWAIT   (D_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_WRITE    (MEM_WRITE),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT),
        .ERROR        (ERROR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            2:       return 32'h0704_0005;
            3:       return 32'h3333_0003;
            7:       return 32'h7777_0007;
            9:       return 32'h9999_0009;
            default: return 32'h1000_0000 | 32'(i * 257);
        endcase
    endfunction

    // ---------------- behavioural memory (stimulus side) ----------------
    logic [31:0] mem [64];
    int          mem_remain = 0;
    bit          mem_done   = 1'b0;
    bit          mem_loaded = 1'b0;
    int          mem_lat    = 0;     // 0: random latency 1..5
    bit          stuck      = 1'b0;  // busy forever

    always @(posedge CLK) begin
        #3;
        if (!RESET) begin
            MEM_BUSYWAIT = 1'b0;
            mem_remain   = 0;
            mem_done     = 1'b0;
            if (!mem_loaded) begin
                for (int i = 0; i < 64; i++) mem[i] = init_val(i);
                mem_loaded = 1'b1;
            end
        end else if (mem_remain > 0) begin
            if (!stuck) begin
                if (mem_remain >= 500) begin
                    mem_remain   = 0;
                    MEM_BUSYWAIT = 1'b0;
                end else begin
                    mem_remain--;
                    if (mem_remain == 0) begin
                        MEM_BUSYWAIT = 1'b0;
                        mem_done     = 1'b1;
                        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
                        else           MEM_READDATA     = mem[MEM_ADDRESS];
                    end
                end
            end
        end else if ((MEM_READ || MEM_WRITE) && !mem_done) begin
            MEM_BUSYWAIT = 1'b1;
            if (stuck)             mem_remain = 1000;
            else if (mem_lat != 0) mem_remain = mem_lat;
            else                   mem_remain = $urandom_range(1, 5);
        end else if (!(MEM_READ || MEM_WRITE)) begin
            mem_done = 1'b0;
        end
    end

    // ---------------- reference model + checking ----------------
    int          checks = 0;
    int          errors = 0;

    logic [31:0] ref_mem [64];
    bit          ref_loaded  = 1'b0;
    int          m_owner     = 0;    // 0 none, 1 I, 2 D: port being served
    int          m_done_port = 0;    // port in its one completion cycle
    int          m_cycles    = 0;
    bit          m_seen      = 1'b0;
    bit          m_last_d    = 1'b0;
    bit          m_wr        = 1'b0;
    logic [5:0]  m_addr      = '0;
    logic [31:0] m_wdata     = '0;
    logic [31:0] m_ird       = '0;
    logic [31:0] m_drd       = '0;
    bit          m_err       = 1'b0;
    logic [5:0]  grant_log [$];
    bit          prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic end_job();
        m_last_d    = (m_owner == 2);
        m_done_port = m_owner;
        m_owner     = 0;
        m_cycles    = 0;
        m_seen      = 1'b0;
    endtask

    task automatic model_step();
        if (!RESET) begin
            m_owner = 0; m_done_port = 0; m_cycles = 0; m_seen = 1'b0;
            m_last_d = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
            m_ird = '0; m_drd = '0; m_err = 1'b0;
            if (!ref_loaded) begin
                for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
                ref_loaded = 1'b1;
            end
        end else if (m_done_port != 0) begin
            m_done_port = 0;
        end else if (m_owner != 0) begin
            m_cycles++;
            if (m_seen && !MEM_BUSYWAIT) begin
                if (m_wr)              ref_mem[m_addr] = m_wdata;
                else if (m_owner == 1) m_ird = ref_mem[m_addr];
                else                   m_drd = ref_mem[m_addr];
                end_job();
            end else if (m_cycles == TMO) begin
                m_err = 1'b1;
                end_job();
            end else if (MEM_BUSYWAIT) begin
                m_seen = 1'b1;
            end
        end else if ((D_READ || D_WRITE) && (!I_READ || !m_last_d)) begin
            m_owner = 2; m_wr = D_WRITE; m_addr = D_ADDRESS; m_wdata = D_WRITEDATA;
        end else if (I_READ) begin
            m_owner = 1; m_wr = 1'b0; m_addr = I_ADDRESS;
        end
    endtask

    task automatic chk_busy();
        chk("I_BUSYWAIT", I_BUSYWAIT, I_READ && (m_done_port != 1));
        chk("D_BUSYWAIT", D_BUSYWAIT, (D_READ || D_WRITE) && (m_done_port != 2));
    endtask

    task automatic compare();
        bit strobe;
        chk("MEM_READ", MEM_READ, (m_owner != 0) && !m_wr);
        chk("MEM_WRITE", MEM_WRITE, (m_owner != 0) && m_wr);
        chk("MEM_ADDRESS", MEM_ADDRESS, m_addr);
        chk("MEM_WRITEDATA", MEM_WRITEDATA, m_wdata);
        chk("I_READDATA", I_READDATA, m_ird);
        chk("D_READDATA", D_READDATA, m_drd);
        chk("ERROR", ERROR, m_err);
        chk_busy();
        strobe = MEM_READ || MEM_WRITE;
        if (strobe && !prev_strobe) grant_log.push_back(MEM_ADDRESS);
        prev_strobe = strobe;
    endtask

    // Called with inputs already driven at a falling edge; returns at the
    // next falling edge after the model has stepped and outputs were checked.
    task automatic cycle();
        #1;
        if (RESET) chk_busy();
        @(posedge CLK);
        model_step();
        #1;
        compare();
        @(negedge CLK);
    endtask

    task automatic wait_port(input bit is_d, input int limit, output int hi_cnt);
        bit ok;
        hi_cnt = 0;
        ok     = 1'b0;
        for (int k = 0; k < limit; k++) begin
            cycle();
            if ((is_d ? D_BUSYWAIT : I_BUSYWAIT) == 1'b0) begin
                ok = 1'b1;
                break;
            end
            hi_cnt++;
        end
        chk("wait_for_done", ok, 1'b1);
    endtask

    initial begin
        int hi;
        int start;

        // 0: reset values
        RESET = 1'b0;
        repeat (3) cycle();
        chk("rst MEM_READ", MEM_READ, 1'b0);
        chk("rst MEM_WRITE", MEM_WRITE, 1'b0);
        chk("rst MEM_ADDRESS", MEM_ADDRESS, 6'h00);
        chk("rst MEM_WRITEDATA", MEM_WRITEDATA, 32'h0);
        chk("rst I_READDATA", I_READDATA, 32'h0);
        chk("rst D_READDATA", D_READDATA, 32'h0);
        chk("rst ERROR", ERROR, 1'b0);
        RESET = 1'b1;
        cycle();

        // 1: D write, memory busy 5 cycles
        mem_lat = 5;
        D_WRITE = 1'b1; D_ADDRESS = 6'h05; D_WRITEDATA = 32'hDEAD_BEEF;
        cycle();
        chk("t1 MEM_WRITE", MEM_WRITE, 1'b1);
        chk("t1 MEM_READ", MEM_READ, 1'b0);
        chk("t1 MEM_ADDRESS", MEM_ADDRESS, 6'h05);
        chk("t1 MEM_WRITEDATA", MEM_WRITEDATA, 32'hDEAD_BEEF);
        wait_port(1'b1, 30, hi);
        chk("t1 D stall cycles", hi, 5);
        D_WRITE = 1'b0;
        cycle();
        chk("t1 mem[5]", mem[5], 32'hDEAD_BEEF);
        chk("t1 D_READDATA kept", D_READDATA, 32'h0);

        // 2: I read of block 2
        mem_lat = 3;
        I_READ = 1'b1; I_ADDRESS = 6'h02;
        wait_port(1'b0, 30, hi);
        chk("t2 I stall cycles", hi, 4);
        I_READ = 1'b0;
        cycle();
        chk("t2 I_READDATA", I_READDATA, 32'h0704_0005);

        // 3: simultaneous requests after reset alternate D, I, D, I
        RESET = 1'b0;
        repeat (2) cycle();
        RESET = 1'b1;
        mem_lat = 2;
        start = grant_log.size();
        I_READ = 1'b1; I_ADDRESS = 6'd10;
        D_READ = 1'b1; D_ADDRESS = 6'd20;
        for (int k = 0; k < 80 && grant_log.size() < start + 4; k++) cycle();
        I_READ = 1'b0; D_READ = 1'b0;
        chk("t3 grant count", grant_log.size() - start, 4);
        if (grant_log.size() >= start + 4) begin
            chk("t3 grant0", grant_log[start],     6'd20);
            chk("t3 grant1", grant_log[start + 1], 6'd10);
            chk("t3 grant2", grant_log[start + 2], 6'd20);
            chk("t3 grant3", grant_log[start + 3], 6'd10);
        end
        repeat (10) cycle();

        // 4: D address changes mid-service are ignored
        mem_lat = 4;
        D_READ = 1'b1; D_ADDRESS = 6'd3;
        cycle();
        cycle();
        D_ADDRESS = 6'd9;
        wait_port(1'b1, 30, hi);
        chk("t4 MEM_ADDRESS", MEM_ADDRESS, 6'd3);
        D_READ = 1'b0;
        cycle();
        chk("t4 D_READDATA", D_READDATA, 32'h3333_0003);

        // 5: memory stuck busy -> timeout
        stuck = 1'b1;
        D_READ = 1'b1; D_ADDRESS = 6'd9;
        cycle();
        wait_port(1'b1, 40, hi);
        chk("t5 serve cycles", hi, TMO - 1);
        chk("t5 ERROR", ERROR, 1'b1);
        chk("t5 D_READDATA kept", D_READDATA, 32'h3333_0003);
        D_READ = 1'b0;
        stuck = 1'b0;
        repeat (5) cycle();
        chk("t5 ERROR sticky", ERROR, 1'b1);
        chk("t5 MEM_READ idle", MEM_READ, 1'b0);

        // 6: reset pulse in the middle of an I service
        mem_lat = 4;
        I_READ = 1'b1; I_ADDRESS = 6'd7;
        cycle();
        cycle();
        chk("t6 MEM_READ before", MEM_READ, 1'b1);
        RESET = 1'b0;
        #1;
        chk("t6 async MEM_READ", MEM_READ, 1'b0);
        chk("t6 async ERROR", ERROR, 1'b0);
        chk("t6 async MEM_ADDRESS", MEM_ADDRESS, 6'd0);
        chk("t6 async I_BUSYWAIT", I_BUSYWAIT, 1'b1);
        cycle();
        cycle();
        RESET = 1'b1;
        wait_port(1'b0, 30, hi);
        chk("t6 regrant stall cycles", hi, 5);
        chk("t6 I_READDATA", I_READDATA, 32'h7777_0007);
        I_READ = 1'b0;
        cycle();

        // 7: random traffic on both ports
        mem_lat = 0;
        for (int c = 0; c < 600; c++) begin
            if (!I_READ) begin
                if ($urandom_range(0, 2) == 0) begin
                    I_READ    = 1'b1;
                    I_ADDRESS = 6'($urandom_range(0, 63));
                end
            end else if (!I_BUSYWAIT) begin
                I_READ = 1'b0;
            end else if ($urandom_range(0, 40) == 0) begin
                I_READ = 1'b0;
            end

            if (!(D_READ || D_WRITE)) begin
                if ($urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       begin D_READ = 1'b1; D_WRITE = 1'b0; end
                        1:       begin D_READ = 1'b0; D_WRITE = 1'b1; end
                        default: begin D_READ = 1'b1; D_WRITE = 1'b1; end
                    endcase
                    D_ADDRESS   = 6'($urandom_range(0, 63));
                    D_WRITEDATA = $urandom;
                end
            end else if (!D_BUSYWAIT) begin
                D_READ = 1'b0; D_WRITE = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                D_ADDRESS   = 6'($urandom_range(0, 63));
                D_WRITEDATA = $urandom;
            end else if ($urandom_range(0, 40) == 0) begin
                D_READ = 1'b0; D_WRITE = 1'b0;
            end
            cycle();
        end
        I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
        repeat (15) cycle();
        chk("final ERROR", ERROR, 1'b0);
        chk("final MEM_READ", MEM_READ, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
